// File: rtl/kpd_pkg.sv
// Shared FSM state, event record and width helpers for the keypad matrix scanner.
// The event record is sized for the largest 8x8 matrix; smaller matrices zero-extend the code.
package kpd_pkg;

  localparam int CODE_MAX_W = 6;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } kpd_state_t;

  typedef struct packed {
    logic                  press;
    logic [CODE_MAX_W-1:0] code;
  } kpd_evt_t;

  // Never returns less than 1 so degenerate counters still get a legal width.
  function automatic int kpd_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int code_width(input int rows, input int cols);
    return kpd_clog2(rows * cols);
  endfunction

endpackage

// File: rtl/kpd_event_fifo.sv
// Event FIFO: head is visible in the cycle vld is high; a pop advances it on the next edge.
// A push into a full FIFO is accepted only alongside a pop, otherwise it is dropped and flagged.
module kpd_event_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             vld,
  output logic [WIDTH-1:0] head,
  output logic             drop
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic [CNTW-1:0]  count_nxt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign do_pop  = pop && vld;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = vld ? mem[rd_ptr] : '0;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNTW'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      vld   <= (count_nxt != '0);
    end
  end

endmodule

// File: rtl/kpd_matrix_scan.sv
// Keypad row scanner with debounce and event FIFO; columns pass a 2-FF synchronizer first.
// Define KPD_REPEAT_EN to add auto-repeat press events while a key is held.
module kpd_matrix_scan
  import kpd_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 1024,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 8,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  localparam int CW             = code_width(ROWS, COLS)
) (
  input  logic            CLK_50M,
  input  logic            RST_N,
  output logic [ROWS-1:0] KPD_R,
  input  logic [COLS-1:0] KPD_C,
  output logic            KPD_state,
  output logic            EVT_VALID,
  input  logic            EVT_READY,
  output logic            EVT_PRESS,
  output logic [CW-1:0]   EVT_CODE,
  output logic            EVT_OVF,
  input  logic            OVF_CLR
);

  localparam int RW  = kpd_clog2(ROWS);
  localparam int CLW = kpd_clog2(COLS);
  localparam int DVW = kpd_clog2(SCAN_DIV);
  localparam int DBW = kpd_clog2(DEBOUNCE_CYCLES);

  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_DIV < 4 ||
      DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("kpd_matrix_scan: illegal parameter set");
  end

  kpd_state_t      state, state_nxt;
  logic [RW-1:0]   row, row_nxt, row_inc;
  logic [CLW-1:0]  col, col_nxt, low_col;
  logic [DVW-1:0]  div_cnt, div_nxt;
  logic [DBW-1:0]  deb_cnt, deb_nxt;
  logic [COLS-1:0] c_meta, c_sync;
  logic            any_low;
  logic            col_low;
  logic            deb_done;
  logic            push;
  logic            push_press;
  logic [CW-1:0]   code;
  kpd_evt_t        push_evt;
  kpd_evt_t        head_evt;
  logic [$bits(kpd_evt_t)-1:0] head_raw;
  logic            drop;
  logic            ovf;

`ifdef KPD_REPEAT_EN
  localparam int RPW = kpd_clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  logic [RPW-1:0] rep_cnt, rep_nxt, rep_lim;
  logic           rep_armed, rep_armed_nxt;
  assign rep_lim = rep_armed ? RPW'(REPEAT_RATE - 1) : RPW'(REPEAT_DELAY - 1);
`endif

  assign KPD_R     = ~(ROWS'(1) << row);
  assign KPD_state = (state == HELD) || (state == DEB_REL);
  assign row_inc   = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
  assign col_low   = !c_sync[col];
  assign deb_done  = (deb_cnt == DBW'(DEBOUNCE_CYCLES - 1));
  assign code      = CW'(int'(row) * COLS + int'(col));

  always_comb begin
    any_low = 1'b0;
    low_col = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!c_sync[i]) begin
        any_low = 1'b1;
        low_col = CLW'(i);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    row_nxt    = row;
    col_nxt    = col;
    div_nxt    = div_cnt;
    deb_nxt    = deb_cnt;
    push       = 1'b0;
    push_press = 1'b0;
`ifdef KPD_REPEAT_EN
    rep_nxt       = rep_cnt;
    rep_armed_nxt = rep_armed;
`endif
    case (state)
      SCAN: begin
        if (div_cnt == DVW'(SCAN_DIV - 1)) begin
          div_nxt = '0;
          if (any_low) begin
            state_nxt = DEB_PRESS;
            col_nxt   = low_col;
          end else begin
            row_nxt = row_inc;
          end
        end else begin
          div_nxt = div_cnt + DVW'(1);
        end
      end
      DEB_PRESS: begin
        if (!col_low) begin
          state_nxt = SCAN;
          row_nxt   = row_inc;
          div_nxt   = '0;
          deb_nxt   = '0;
        end else if (deb_done) begin
          state_nxt  = HELD;
          push       = 1'b1;
          push_press = 1'b1;
          deb_nxt    = '0;
`ifdef KPD_REPEAT_EN
          rep_nxt       = '0;
          rep_armed_nxt = 1'b0;
`endif
        end else begin
          deb_nxt = deb_cnt + DBW'(1);
        end
      end
      HELD: begin
        if (!col_low) begin
          state_nxt = DEB_REL;
          deb_nxt   = '0;
        end
`ifdef KPD_REPEAT_EN
        else if (rep_cnt == rep_lim) begin
          push          = 1'b1;
          push_press    = 1'b1;
          rep_nxt       = '0;
          rep_armed_nxt = 1'b1;
        end else begin
          rep_nxt = rep_cnt + RPW'(1);
        end
`endif
      end
      DEB_REL: begin
        if (col_low) begin
          state_nxt = HELD;
          deb_nxt   = '0;
        end else if (deb_done) begin
          state_nxt = SCAN;
          push      = 1'b1;
          row_nxt   = '0;
          div_nxt   = '0;
          deb_nxt   = '0;
        end else begin
          deb_nxt = deb_cnt + DBW'(1);
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      c_meta  <= '1;
      c_sync  <= '1;
      state   <= SCAN;
      row     <= '0;
      col     <= '0;
      div_cnt <= '0;
      deb_cnt <= '0;
      ovf     <= 1'b0;
`ifdef KPD_REPEAT_EN
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
`endif
    end else begin
      c_meta  <= KPD_C;
      c_sync  <= c_meta;
      state   <= state_nxt;
      row     <= row_nxt;
      col     <= col_nxt;
      div_cnt <= div_nxt;
      deb_cnt <= deb_nxt;
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        ovf <= 1'b1;
      end else if (OVF_CLR) begin
        ovf <= 1'b0;
      end
`ifdef KPD_REPEAT_EN
      rep_cnt   <= rep_nxt;
      rep_armed <= rep_armed_nxt;
`endif
    end
  end

  always_comb begin
    push_evt       = '0;
    push_evt.press = push_press;
    push_evt.code  = CODE_MAX_W'(code);
  end

  kpd_event_fifo #(
    .WIDTH ($bits(kpd_evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK_50M),
    .rst_n    (RST_N),
    .push     (push),
    .push_dat (push_evt),
    .pop      (EVT_READY),
    .vld      (EVT_VALID),
    .head     (head_raw),
    .drop     (drop)
  );

  assign head_evt  = head_raw;
  assign EVT_PRESS = head_evt.press;
  assign EVT_CODE  = head_evt.code[CW-1:0];
  assign EVT_OVF   = ovf;

endmodule

// File: doc/kpd_matrix_scan.md
KPD_MATRIX_SCAN -- requirements
Module: kpd_matrix_scan

Interface
REQ-001 Parameter ROWS, default 4: number of driven row lines, range 2-8.
REQ-002 Parameter COLS, default 4: number of sensed column lines, range 2-8.
REQ-003 Parameter SCAN_DIV, default 1024: dwell cycles per row, at least 4.
REQ-004 Parameter DEBOUNCE_CYCLES, default 500000: stable cycles required to accept a press or release.
REQ-005 Parameter FIFO_DEPTH, default 8: event buffer entries, power of two, at least 2.
REQ-006 Parameter REPEAT_DELAY, default 25000000; REPEAT_RATE, default 5000000: auto-repeat timing in cycles.
REQ-007 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-008 CLK_50M  in  1  system clock; all state on its rising edge.
REQ-009 RST_N  in  1  asynchronous active-low reset.
REQ-010 KPD_R  out  ROWS  row drive, active-low one-hot; exactly one bit low at all times.
REQ-011 KPD_C  in  COLS  column sense, active-low, asynchronous to CLK_50M.
REQ-012 KPD_state  out  1  high while a debounced key is held.
REQ-013 EVT_VALID  out  1  FIFO non-empty.
REQ-014 EVT_READY  in  1  consumer pop strobe; a pop occurs when EVT_VALID and EVT_READY are both high.
REQ-015 EVT_PRESS  out  1  head event type: 1 = press or repeat, 0 = release.
REQ-016 EVT_CODE  out  CW  head key code, row*COLS+col; CW = clog2(ROWS*COLS).
REQ-017 EVT_OVF  out  1  sticky flag: an event was dropped.
REQ-018 OVF_CLR  in  1  synchronous clear of EVT_OVF.

Function
REQ-019 KPD_C SHALL pass through a 2-FF synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-020 FSM states SHALL be SCAN, DEB_PRESS, HELD and DEB_REL.
- SCAN: advance the row every SCAN_DIV cycles, wrapping from ROWS-1 to 0.
- Sample the columns on the last dwell cycle.
- If any column is low: latch row and lowest-index low column, enter DEB_PRESS, freeze the row.
REQ-021 DEB_PRESS: the latched column SHALL stay low for DEBOUNCE_CYCLES consecutive cycles.
- Then push {1, code}, enter HELD, and raise KPD_state on the same edge.
- Any high sample restarts SCAN at the next row with no event.
REQ-022 HELD: a high sample on the latched column SHALL enter DEB_REL.
- Other columns are ignored; no rollover.
REQ-023 DEB_REL: DEBOUNCE_CYCLES consecutive high samples SHALL push {0, code}, drop KPD_state, and enter SCAN at row 0.
- A low sample returns to HELD with no event.
REQ-024 FIFO write and read SHALL take effect in the same cycle if both are requested.
- When full, a push with a simultaneous pop is accepted.
- When full, a push without a pop is dropped and EVT_OVF is set.
REQ-025 Head outputs SHALL update on the edge after a pop; EVT_VALID is a registered output with 0-cycle show-ahead.
REQ-026 If OVF_CLR and a drop occur in the same cycle, EVT_OVF SHALL end high (set wins).
REQ-027 All counters SHALL saturate or reload; none overflows silently.

Reset
REQ-028 While RST_N is low, the FSM SHALL be in SCAN with row 0.
- Outputs: KPD_R = all ones except bit0 low; KPD_state = 0; EVT_VALID = 0; EVT_PRESS = 0; EVT_CODE = 0; EVT_OVF = 0.
- FIFO empty; all counters 0.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL discard the pending key with no event.

Configuration
REQ-030 With KPD_REPEAT_EN defined, HELD SHALL push {1, code} REPEAT_DELAY cycles after entry, then every REPEAT_RATE cycles while held.
REQ-031 Without KPD_REPEAT_EN, no repeat logic SHALL exist and HELD emits no events.

Structure
REQ-032 Package kpd_pkg SHALL hold:
- the FSM state enum;
- the event record type {press, code};
- a code-width function.
REQ-033 The FIFO SHALL be sub-module kpd_event_fifo (parametrised on width and depth); the scan FSM stays in kpd_matrix_scan.

Verification
REQ-034 Bench parameters: ROWS=3, COLS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=16, FIFO_DEPTH=4, REPEAT_DELAY=64, REPEAT_RATE=16.
- Scenario 1: hold row1/col2 for 200 cycles, then release -> two events, {1,6} then {0,6}; KPD_state high between them.
- Scenario 2: 8-cycle glitch on col0 -> no event; scan resumes.
- Scenario 3: 6 press/release pairs with EVT_READY=0 -> 4 events buffered, EVT_OVF=1, first 4 codes in order.
- Scenario 4: full FIFO with simultaneous push and pop -> occupancy stays 4; EVT_OVF unchanged.
- Scenario 5: reset asserted during DEB_PRESS -> FIFO empty, KPD_R=110, no event after release.
- Scenario 6 (KPD_REPEAT_EN): hold 120 cycles -> press, repeats at +64 and +80 relative to HELD entry, release.
